// File: rtl/adder16_arbiter_if.sv
// adder16_arbiter_if: request/adder/response bundle between two requesters, the arbiter and the shared adder.
interface adder16_arbiter_if #(parameter int W = 16);
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] add_a, add_b, add_s;
    logic         rsp_valid, rsp_id, rsp_of, rsp_sf, rsp_zf;
    logic [W-1:0] rsp_data;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_s,
        input  req0_ready, req1_ready, add_a, add_b,
        input  rsp_valid, rsp_id, rsp_data, rsp_of, rsp_sf, rsp_zf
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_s,
        output req0_ready, req1_ready, add_a, add_b,
        output rsp_valid, rsp_id, rsp_data, rsp_of, rsp_sf, rsp_zf
    );
endinterface

// File: rtl/adder16_arbiter.sv
// adder16_arbiter: shares one external adder between two requesters and returns the registered sum and COMET2 flags.
module adder16_arbiter #(
    parameter int W          = 16,
    parameter int FIXED_PRIO = 0
) (
    input logic               clk,
    input logic               rst_n,
    adder16_arbiter_if.slave  bus
);
    localparam logic FIXED = FIXED_PRIO != 0;
    logic last_grant, g0, g1, acc;
    // Port 0 wins unless port 1 is alone or round-robin says port 0 went last.
    always_comb begin
        g0 = rst_n & bus.req0_valid & (~bus.req1_valid | FIXED | last_grant);
        g1 = rst_n & bus.req1_valid & ~g0;
        acc = g0 | g1;
        bus.req0_ready = g0;
        bus.req1_ready = g1;
        bus.add_a = g0 ? bus.req0_a : g1 ? bus.req1_a : '0;
        bus.add_b = g0 ? bus.req0_b : g1 ? bus.req1_b : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_of    <= 1'b0;
            bus.rsp_sf    <= 1'b0;
            bus.rsp_zf    <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            bus.rsp_valid <= acc;
            if (acc) begin
                bus.rsp_id    <= g1;
                bus.rsp_data  <= bus.add_s;
                bus.rsp_of    <= (bus.add_a[W-1] == bus.add_b[W-1]) & (bus.add_s[W-1] != bus.add_a[W-1]);
                bus.rsp_sf    <= bus.add_s[W-1];
                bus.rsp_zf    <= bus.add_s == '0;
                last_grant    <= g1;
            end
        end
    end
endmodule

// File: tb/tb_adder16_arbiter.sv
// tb_adder16_arbiter: round-robin and fixed-priority instances driven in parallel against a behavioural model.
module tb_adder16_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    adder16_arbiter_if #(.W(16)) bus_rr ();
    adder16_arbiter_if #(.W(16)) bus_fp ();

    adder16_arbiter #(.W(16), .FIXED_PRIO(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
    adder16_arbiter #(.W(16), .FIXED_PRIO(1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));

    assign bus_rr.req0_valid = v0;
    assign bus_rr.req0_a = a0;
    assign bus_rr.req0_b = b0;
    assign bus_rr.req1_valid = v1;
    assign bus_rr.req1_a = a1;
    assign bus_rr.req1_b = b1;
    assign bus_rr.add_s = bus_rr.add_a + bus_rr.add_b;
    assign bus_fp.req0_valid = v0;
    assign bus_fp.req0_a = a0;
    assign bus_fp.req0_b = b0;
    assign bus_fp.req1_valid = v1;
    assign bus_fp.req1_a = a1;
    assign bus_fp.req1_b = b1;
    assign bus_fp.add_s = bus_fp.add_a + bus_fp.add_b;

    logic        r0 [2], r1 [2], rv [2], rid [2], rof [2], rsf [2], rzf [2];
    logic [15:0] aa [2], ab [2], rd [2];
    assign r0[0] = bus_rr.req0_ready;
    assign r1[0] = bus_rr.req1_ready;
    assign aa[0] = bus_rr.add_a;
    assign ab[0] = bus_rr.add_b;
    assign rv[0] = bus_rr.rsp_valid;
    assign rid[0] = bus_rr.rsp_id;
    assign rd[0] = bus_rr.rsp_data;
    assign rof[0] = bus_rr.rsp_of;
    assign rsf[0] = bus_rr.rsp_sf;
    assign rzf[0] = bus_rr.rsp_zf;
    assign r0[1] = bus_fp.req0_ready;
    assign r1[1] = bus_fp.req1_ready;
    assign aa[1] = bus_fp.add_a;
    assign ab[1] = bus_fp.add_b;
    assign rv[1] = bus_fp.rsp_valid;
    assign rid[1] = bus_fp.rsp_id;
    assign rd[1] = bus_fp.rsp_data;
    assign rof[1] = bus_fp.rsp_of;
    assign rsf[1] = bus_fp.rsp_sf;
    assign rzf[1] = bus_fp.rsp_zf;

    // Reference model: index 0 is the round-robin instance, index 1 the fixed-priority one.
    int last [2], mid [2], md [2];
    int mv [2], mof [2], msf [2], mzf [2];

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            last[d] = 1; mv[d] = 0; mid[d] = 0; md[d] = 0;
            mof[d] = 0; msf[d] = 0; mzf[d] = 0;
        end
    endtask

    function automatic int win(int d);
        if (!rst_n || (!v0 && !v1)) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (d == 1) return 0;
        return (last[d] == 0) ? 1 : 0;
    endfunction

    function automatic int sgn(int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic chk(string nm, int d, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    task automatic step();
        int gs [2];
        int x, y, s, t;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            gs[d] = win(d);
            chk("req0_ready", d, int'(r0[d]), int'(gs[d] == 0));
            chk("req1_ready", d, int'(r1[d]), int'(gs[d] == 1));
            chk("add_a", d, int'(aa[d]), gs[d] == 0 ? int'(a0) : gs[d] == 1 ? int'(a1) : 0);
            chk("add_b", d, int'(ab[d]), gs[d] == 0 ? int'(b0) : gs[d] == 1 ? int'(b1) : 0);
        end
        @(posedge clk);
        #1;
        if (!rst_n) mreset();
        for (int d = 0; d < 2; d++) begin
            if (rst_n && gs[d] >= 0) begin
                x = gs[d] == 0 ? int'(a0) : int'(a1);
                y = gs[d] == 0 ? int'(b0) : int'(b1);
                s = (x + y) % 65536;
                t = sgn(x) + sgn(y);
                mv[d] = 1; mid[d] = gs[d]; md[d] = s; last[d] = gs[d];
                mof[d] = int'(t > 32767 || t < -32768);
                msf[d] = int'(s >= 32768);
                mzf[d] = int'(s == 0);
            end else mv[d] = 0;
            chk("rsp_valid", d, int'(rv[d]), mv[d]);
            chk("rsp_id", d, int'(rid[d]), mid[d]);
            chk("rsp_data", d, int'(rd[d]), md[d]);
            chk("rsp_of", d, int'(rof[d]), mof[d]);
            chk("rsp_sf", d, int'(rsf[d]), msf[d]);
            chk("rsp_zf", d, int'(rzf[d]), mzf[d]);
        end
    endtask

    typedef struct {
        logic v0; logic [15:0] a0, b0;
        logic v1; logic [15:0] a1, b1;
        int id, data, of, sf, zf;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [15:0] pick();
        logic [15:0] edges [6];
        edges[0] = 16'h0000; edges[1] = 16'h0001; edges[2] = 16'h7FFF;
        edges[3] = 16'h8000; edges[4] = 16'hFFFF; edges[5] = 16'h8001;
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
    endfunction

    initial begin
        tbl[0] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0FFF, 1, 16'h2233, 0, 0, 0};
        tbl[1] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 1};
        tbl[2] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7FFF, 16'h0001, 1, 16'h8000, 1, 1, 0};
        tbl[4] = '{1'b1, 16'h0005, 16'hFFFD, 1'b0, 16'h0000, 16'h0000, 0, 16'h0002, 0, 0, 0};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8001, 16'hFFFF, 1, 16'h8000, 0, 1, 0};
        mreset();
        // Held in reset with both ports requesting: no ready, no response.
        v0 = 1'b1; v1 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; a1 = 16'h3333; b1 = 16'h4444;
        step();
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            v0 = tbl[i].v0; a0 = tbl[i].a0; b0 = tbl[i].b0;
            v1 = tbl[i].v1; a1 = tbl[i].a1; b1 = tbl[i].b1;
            step();
            for (int d = 0; d < 2; d++) begin
                chk("tbl_valid", d, int'(rv[d]), 1);
                chk("tbl_id", d, int'(rid[d]), tbl[i].id);
                chk("tbl_data", d, int'(rd[d]), tbl[i].data);
                chk("tbl_of", d, int'(rof[d]), tbl[i].of);
                chk("tbl_sf", d, int'(rsf[d]), tbl[i].sf);
                chk("tbl_zf", d, int'(rzf[d]), tbl[i].zf);
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        step();
        chk("idle_hold_data", 0, int'(rd[0]), 16'h8000);
        // Contention straight after reset: round-robin alternates from port 0, fixed priority starves port 1.
        rst_n = 1'b0; #1; mreset(); step(); rst_n = 1'b1;
        v0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001;
        v1 = 1'b1; a1 = 16'h7FFF; b1 = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_alt_id", 0, int'(rid[0]), i % 2);
            chk("rr_alt_data", 0, int'(rd[0]), (i % 2) ? 16'h8000 : 16'h0002);
            chk("rr_alt_of", 0, int'(rof[0]), i % 2);
            chk("fp_id", 1, int'(rid[1]), 0);
            chk("fp_data", 1, int'(rd[1]), 16'h0002);
            chk("fp_ready1", 1, int'(r1[1]), 0);
        end
        // Reset just after acceptance: response must vanish asynchronously and never reappear.
        v1 = 1'b0; a0 = 16'h4000; b0 = 16'h0123;
        step();
        rst_n = 1'b0;
        #1;
        mreset();
        chk("async_clr_valid", 0, int'(rv[0]), 0);
        chk("async_clr_valid", 1, int'(rv[1]), 0);
        chk("async_clr_data", 0, int'(rd[0]), 0);
        step();
        v0 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_quiet", 0, int'(rv[0]), 0);
        v0 = 1'b1; v1 = 1'b1; a0 = 16'h0010; b0 = 16'h0020; a1 = 16'h0100; b1 = 16'h0200;
        step();
        chk("post_rst_tie_id", 0, int'(rid[0]), 0);
        chk("post_rst_tie_data", 0, int'(rd[0]), 16'h0030);
        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            a0 = pick(); b0 = pick(); a1 = pick(); b1 = pick();
            if (i % 97 == 96) begin
                rst_n = 1'b0; #1; mreset(); step(); rst_n = 1'b1;
            end else step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
